// File: rtl/seg_pattern_reader.sv
// Purpose : recovers BCD digits from a multiplexed active-low seven-segment bus (sync, stability filter, decode).
// Latency : a stable input sampled first at edge 0 is captured and visible after edge STABLE_CYCLES+1.
// Backpres: none; the display bus is free-running and sampled every cycle. Optional SEG_READER_ERR_COUNT_EN adds err_count.
module seg_pattern_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_sel_n,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] digit_values,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    code_err
`ifdef SEG_READER_ERR_COUNT_EN
   ,
   output logic [7:0]              err_count
`endif
);

   // Counter must be able to hold STABLE_CYCLES itself (saturated value after a capture).
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HELD  = 2'd2
   } state_t;

   // Two-flop synchronisers; reset to all-ones = blank segments, no digit selected.
   logic [6:0]            seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [NUM_DIGITS-1:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;

   // Filter state.
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [6:0]            prev_seg_q, prev_seg_d;
   logic [NUM_DIGITS-1:0] prev_sel_q, prev_sel_d;

   // Captured state.
   logic [4*NUM_DIGITS-1:0] values_q, values_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic                    frame_q, frame_d;
   logic                    err_q, err_d;
`ifdef SEG_READER_ERR_COUNT_EN
   logic [7:0]              errcnt_q, errcnt_d;
`endif

   // Derived combinational signals.
   logic [NUM_DIGITS-1:0] sel_hot;
   logic                  sel_legal;
   logic                  sample_match;
   logic [6:0]            seg_lit;
   logic                  dec_ok;
   logic                  dec_blank;
   logic [3:0]            dec_val;
   logic                  capture;
   logic [NUM_DIGITS-1:0] mask_upd;

   // Synchroniser next-state: each stage simply shifts the previous one.
   always_comb begin
      seg_s1_d = seg_n;
      seg_s2_d = seg_s1_q;
      sel_s1_d = dig_sel_n;
      sel_s2_d = sel_s1_q;
   end

   // Synchroniser registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q <= '1;
         seg_s2_q <= '1;
         sel_s1_q <= '1;
         sel_s2_q <= '1;
      end else begin
         seg_s1_q <= seg_s1_d;
         seg_s2_q <= seg_s2_d;
         sel_s1_q <= sel_s1_d;
         sel_s2_q <= sel_s2_d;
      end
   end

   // Select legality: exactly one active-low select bit; compare sample with the tracked one.
   always_comb begin
      sel_hot      = ~sel_s2_q;
      sel_legal    = (sel_hot != '0) && ((sel_hot & (sel_hot - SEL_ONE)) == '0);
      sample_match = (sel_s2_q == prev_sel_q) && (seg_s2_q == prev_seg_q);
   end

   // Pattern decoder: exact match on lit segments {g,f,e,d,c,b,a}.
   always_comb begin
      seg_lit   = ~seg_s2_q;
      dec_ok    = 1'b1;
      dec_val   = 4'd0;
      dec_blank = (seg_lit == 7'h00);
      case (seg_lit)
         7'h3F:   dec_val = 4'd0;
         7'h06:   dec_val = 4'd1;
         7'h5B:   dec_val = 4'd2;
         7'h4F:   dec_val = 4'd3;
         7'h66:   dec_val = 4'd4;
         7'h6D:   dec_val = 4'd5;
         7'h7D:   dec_val = 4'd6;
         7'h07:   dec_val = 4'd7;
         7'h7F:   dec_val = 4'd8;
         7'h6F:   dec_val = 4'd9;
         default: dec_ok  = 1'b0;
      endcase
   end

   // Stability filter FSM: next state, counter and the single capture strike per stable period.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prev_sel_d = prev_sel_q;
      prev_seg_d = prev_seg_q;
      capture    = 1'b0;
      if (!sel_legal) begin
         state_d = IDLE;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = TRACK;
               prev_sel_d = sel_s2_q;
               prev_seg_d = seg_s2_q;
               cnt_d      = CNT_ONE;
            end
            TRACK: begin
               if (sample_match) begin
                  if (cnt_q == CNT_CAP) begin
                     capture = 1'b1;
                     state_d = HELD;
                     cnt_d   = CNT_FULL;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  prev_sel_d = sel_s2_q;
                  prev_seg_d = seg_s2_q;
                  cnt_d      = CNT_ONE;
               end
            end
            HELD: begin
               // Already captured this pattern; only a change restarts tracking.
               if (!sample_match) begin
                  state_d    = TRACK;
                  prev_sel_d = sel_s2_q;
                  prev_seg_d = seg_s2_q;
                  cnt_d      = CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
      if (clear) begin
         state_d = IDLE;
         cnt_d   = CNT_ZERO;
      end
   end

   // FSM and tracking registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= CNT_ZERO;
         prev_sel_q <= '1;
         prev_seg_q <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_sel_q <= prev_sel_d;
         prev_seg_q <= prev_seg_d;
      end
   end

   // Capture update: valid digits fill the frame mask, bad patterns raise the sticky error; clear wins.
   always_comb begin
      values_d = values_q;
      valid_d  = valid_q;
      mask_d   = mask_q;
      err_d    = err_q;
      frame_d  = 1'b0;
      mask_upd = mask_q | sel_hot;
`ifdef SEG_READER_ERR_COUNT_EN
      errcnt_d = errcnt_q;
`endif
      if (capture) begin
         if (dec_ok) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
               if (sel_hot[d]) begin
                  values_d[4*d +: 4] = dec_val;
               end
            end
            valid_d = valid_q | sel_hot;
            if (&mask_upd) begin
               // Frame complete: pulse and start collecting the next frame.
               frame_d = 1'b1;
               mask_d  = '0;
            end else begin
               mask_d = mask_upd;
            end
         end else if (!dec_blank) begin
            err_d   = 1'b1;
            valid_d = valid_q & ~sel_hot;
`ifdef SEG_READER_ERR_COUNT_EN
            errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
`endif
         end
      end
      if (clear) begin
         values_d = '0;
         valid_d  = '0;
         mask_d   = '0;
         err_d    = 1'b0;
         frame_d  = 1'b0;
`ifdef SEG_READER_ERR_COUNT_EN
         errcnt_d = 8'd0;
`endif
      end
   end

   // Captured-state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         values_q <= '0;
         valid_q  <= '0;
         mask_q   <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
`ifdef SEG_READER_ERR_COUNT_EN
         errcnt_q <= 8'd0;
`endif
      end else begin
         values_q <= values_d;
         valid_q  <= valid_d;
         mask_q   <= mask_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
`ifdef SEG_READER_ERR_COUNT_EN
         errcnt_q <= errcnt_d;
`endif
      end
   end

   assign digit_values = values_q;
   assign digit_valid  = valid_q;
   assign frame_done   = frame_q;
   assign code_err     = err_q;
`ifdef SEG_READER_ERR_COUNT_EN
   assign err_count    = errcnt_q;
`endif

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Purpose : self-checking bench for seg_pattern_reader (default NUM_DIGITS=4, STABLE_CYCLES=4).
// Latency : expects a capture visible after the 6th rising edge following an input change.
// Backpres: n/a; inputs are driven on falling edges, outputs sampled on falling edges.
module tb_seg_pattern_reader;

   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h7E;   // only segment a lit: not a digit
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct {
      string      name;
      logic [3:0] sel;
      logic [6:0] seg;
      int         cyc;
      logic [15:0] vals;
      logic [3:0] valid;
      logic       err;
      int         frames;
      int         errcnt;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [6:0]  seg_n;
   logic [3:0]  dig_sel_n;
   logic [15:0] digit_values;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        code_err;
`ifdef SEG_READER_ERR_COUNT_EN
   logic [7:0]  err_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int frame_cnt = 0;

   vec_t vecs[13];
   vec_t sb[$];

   seg_pattern_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_n        (seg_n),
      .dig_sel_n    (dig_sel_n),
      .clear        (clear),
      .digit_values (digit_values),
      .digit_valid  (digit_valid),
      .frame_done   (frame_done),
      .code_err     (code_err)
`ifdef SEG_READER_ERR_COUNT_EN
      ,
      .err_count    (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count frame pulses shortly after each rising edge; a pulse longer than one cycle counts twice.
   always @(posedge clk) begin
      #1;
      if (frame_done === 1'b1) frame_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required to have finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
      @(negedge clk);
      dig_sel_n = sel;
      seg_n     = seg;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      int f0;
      vec_t e;

      // name, sel, seg, cycles, values, valid, err, frame pulses, err_count
      vecs[0]  = '{"scan1_d0",   4'b1110, SEG_1, 8,  16'h0001, 4'b0001, 1'b0, 0, 0};
      vecs[1]  = '{"scan1_d1",   4'b1101, SEG_2, 8,  16'h0021, 4'b0011, 1'b0, 0, 0};
      vecs[2]  = '{"scan1_d2",   4'b1011, SEG_3, 8,  16'h0321, 4'b0111, 1'b0, 0, 0};
      vecs[3]  = '{"scan1_d3",   4'b0111, SEG_4, 8,  16'h4321, 4'b1111, 1'b0, 1, 0};
      vecs[4]  = '{"scan2_d0",   4'b1110, SEG_1, 8,  16'h4321, 4'b1111, 1'b0, 0, 0};
      vecs[5]  = '{"scan2_d1",   4'b1101, SEG_2, 8,  16'h4321, 4'b1111, 1'b0, 0, 0};
      vecs[6]  = '{"scan2_d2",   4'b1011, SEG_3, 8,  16'h4321, 4'b1111, 1'b0, 0, 0};
      vecs[7]  = '{"scan2_d3",   4'b0111, SEG_4, 8,  16'h4321, 4'b1111, 1'b0, 1, 0};
      vecs[8]  = '{"d2_five",    4'b1011, SEG_5, 8,  16'h4521, 4'b1111, 1'b0, 0, 0};
      vecs[9]  = '{"d2_bad",     4'b1011, SEG_A, 8,  16'h4521, 4'b1011, 1'b1, 0, 1};
      vecs[10] = '{"two_sel",    4'b1100, SEG_1, 10, 16'h4521, 4'b1011, 1'b1, 0, 1};
      vecs[11] = '{"blank_d0",   4'b1110, SEG_BLANK, 10, 16'h4521, 4'b1011, 1'b1, 0, 1};
      vecs[12] = '{"d0_nine",    4'b1110, SEG_9, 8,  16'h4529, 4'b1011, 1'b1, 0, 1};

      rst_n     = 1'b0;
      clear     = 1'b0;
      seg_n     = SEG_BLANK;
      dig_sel_n = 4'hF;
      cycles(2);
      check("rst_values", digit_values, 16'h0000);
      check("rst_valid", digit_valid, 4'h0);
      check("rst_frame", frame_done, 1'b0);
      check("rst_err", code_err, 1'b0);
`ifdef SEG_READER_ERR_COUNT_EN
      check("rst_errcnt", err_count, 8'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);

      // Capture latency on digit 0 showing "7".
      f0 = frame_cnt;
      drive(4'b1110, SEG_7);
      cycles(5);
      check("lat_not_yet", digit_valid, 4'b0000);
      cycles(1);
      check("lat_valid", digit_valid, 4'b0001);
      check("lat_value", digit_values[3:0], 4'd7);
      cycles(14);
      check("hold_value", digit_values, 16'h0007);
      check("hold_no_frame", frame_cnt - f0, 0);

      // A "3" shown for only three cycles must be filtered out.
      drive(4'b1110, SEG_3);
      cycles(2);
      drive(4'b1110, SEG_8);
      cycles(5);
      check("glitch_not_3", digit_values[3:0], 4'd7);
      cycles(1);
      check("eight_captured", digit_values[3:0], 4'd8);
      cycles(4);

      drive(4'hF, SEG_BLANK);
      cycles(3);
      pulse_clear();
      check("clr_values", digit_values, 16'h0000);
      check("clr_valid", digit_valid, 4'h0);

      // Table: scans, error pattern, illegal select, blank.
      for (int i = 0; i < 13; i++) begin
         f0 = frame_cnt;
         drive(vecs[i].sel, vecs[i].seg);
         sb.push_back(vecs[i]);
         cycles(vecs[i].cyc);
         e = sb.pop_front();
         check({e.name, "_values"}, digit_values, e.vals);
         check({e.name, "_valid"}, digit_valid, e.valid);
         check({e.name, "_err"}, code_err, e.err);
         check({e.name, "_frames"}, frame_cnt - f0, e.frames);
`ifdef SEG_READER_ERR_COUNT_EN
         check({e.name, "_errcnt"}, err_count, e.errcnt);
`endif
      end

      // Blank on a single select after clear: nothing captured, no error.
      drive(4'hF, SEG_BLANK);
      cycles(2);
      pulse_clear();
      drive(4'b1110, SEG_BLANK);
      cycles(10);
      check("blank_no_err", code_err, 1'b0);
      check("blank_no_cap", digit_valid, 4'h0);

      // Reset while tracking with count at 2.
      drive(4'b1110, SEG_7);
      cycles(8);
      check("pre_rst_valid", digit_valid, 4'b0001);
      drive(4'b1101, SEG_6);
      cycles(4);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_values", digit_values, 16'h0000);
      check("midrst_valid", digit_valid, 4'h0);
      check("midrst_frame", frame_done, 1'b0);
      check("midrst_err", code_err, 1'b0);
      dig_sel_n = 4'hF;
      seg_n     = SEG_BLANK;
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);
      check("after_rst_valid", digit_valid, 4'h0);

      // Clear landing on the edge that would capture digit 0 and complete a frame.
      drive(4'b1101, SEG_1);
      cycles(8);
      drive(4'b1011, SEG_2);
      cycles(8);
      drive(4'b0111, SEG_3);
      cycles(8);
      drive(4'b0111, SEG_A);
      cycles(8);
      check("setup_err", code_err, 1'b1);
      check("setup_valid", digit_valid, 4'b0110);
      f0 = frame_cnt;
      drive(4'b1110, SEG_7);
      cycles(4);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clrcap_values", digit_values, 16'h0000);
      check("clrcap_valid", digit_valid, 4'h0);
      check("clrcap_err", code_err, 1'b0);
      check("clrcap_frame", frame_cnt - f0, 0);
`ifdef SEG_READER_ERR_COUNT_EN
      check("clrcap_errcnt", err_count, 8'd0);
`endif
      cycles(10);
      check("post_clr_valid", digit_valid, 4'b0001);
      check("post_clr_value", digit_values, 16'h0007);
      check("post_clr_no_frame", frame_cnt - f0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_pattern_reader.md
Name: seg_pattern_reader

Overview:
- Receive-side counterpart to the team's BCD-to-seven-segment decoder: samples a multiplexed, active-low seven-segment display bus (segment lines plus digit selects) and recovers the BCD digit shown on each position.
- Used as a loop-back monitor on display outputs and to read external seven-segment displays.
- Synchronises the asynchronous inputs, filters glitches with a stability counter, decodes patterns to 0-9, and reports per-digit values, a frame-complete strobe and a sticky error flag.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before capture (2..255).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_n  input  7  active-low segments {g,f,e,d,c,b,a}; bit0 = a; 0 = segment lit; asynchronous.
- dig_sel_n  input  NUM_DIGITS  active-low digit select; bit i selects digit i; asynchronous.
- clear  input  1  synchronous clear of captured state, active-high.
- digit_values  output  4*NUM_DIGITS  BCD value of digit i in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set when digit i holds a valid decoded value.
- frame_done  output  1  one-cycle pulse when every digit has been validly captured since the last pulse or clear.
- code_err  output  1  sticky; set on any non-blank pattern that does not decode.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - digit_values=0, digit_valid=0, frame_done=0, code_err=0.
  - Internal capture mask=0, FSM=IDLE, counter=0.
  - Both synchroniser stages load all-ones (blank, nothing selected).
- Synchronisation: seg_n and dig_sel_n each pass through a 2-flop synchroniser. The filter sees only the stage-2 outputs (s_seg, s_sel).
- Select is legal only when exactly one bit of s_sel is 0. Zero or multiple low bits are illegal.
- FSM (states IDLE, TRACK, HELD). Each cycle:
  - Illegal select, from any state -> IDLE, cnt=0.
  - IDLE with legal select -> TRACK; latch prev_sel=s_sel, prev_seg=s_seg; cnt=1.
  - TRACK, sample equals prev -> cnt+1. When cnt==STABLE_CYCLES-1 and the sample still matches: perform capture, go to HELD.
  - TRACK, sample differs -> stay in TRACK; reload prev; cnt=1.
  - HELD, sample equals prev -> stay in HELD; no further capture.
  - HELD, sample differs -> TRACK; reload prev; cnt=1.
- Decode table (lit segments -> value):
  - abcdef=0, bc=1, abdeg=2, abcdg=3, bcfg=4, acdfg=5, acdefg=6, abc=7, abcdefg=8, abcdfg=9.
  - Exact match only.
- Capture, for digit index i of the low select bit:
  - Valid pattern: digit_values[i] <= value; digit_valid[i] <= 1; mask[i] <= 1.
  - Blank pattern (seg_n=7'h7F): no update, no error.
  - Any other pattern: code_err <= 1; digit_valid[i] <= 0; digit_values[i] unchanged; mask[i] unchanged.
- Latency: count edge 0 as the first edge that samples a new stable input. The capture result is visible after edge STABLE_CYCLES+1 (edge 5 for the default).
- Frame:
  - When a capture makes the mask all ones, frame_done=1 on that same edge and the mask clears to 0 in that cycle.
  - digit_valid is not affected.
  - frame_done is 0 in every other cycle.
- clear=1 (synchronous): zeroes digit_values, digit_valid, mask and code_err; FSM -> IDLE; cnt=0.
  - clear overrides a capture or frame_done in the same cycle; frame_done=0 that cycle.
- rst_n asserted mid-TRACK or mid-HELD aborts immediately; no partial capture.
- Counter width is sized to hold STABLE_CYCLES. The counter never wraps.

Optional Feature:
- Macro SEG_READER_ERR_COUNT_EN.
- Defined:
  - Adds output err_count[7:0]: count of invalid-pattern captures.
  - Saturates at 255.
  - Reset and clear set it to 0.
  - Increments on the same edge that sets code_err.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults. dig_sel_n=4'b1110, seg_n with a,b,c lit (7'b1111000), held 20 cycles -> after edge 5: digit_values[3:0]=7, digit_valid=4'b0001. No further capture; frame_done stays 0.
- Pattern "3" held 3 cycles then switched to "8" held 10 cycles on digit 0 -> "3" never captured; value 8 appears 5 edges after the "8" is first sampled.
- Scan digits 0..3 showing 1,2,3,4, 8 cycles each -> digit_values=16'h4321, digit_valid=4'hF. frame_done pulses exactly once, on the digit-3 capture edge. A second full scan gives a second single pulse.
- Digit 2 holds a valid 5, then shows only segment a lit for 8 cycles -> code_err=1, digit_valid[2]=0, digit_values[11:8] stays 5. With the macro: err_count=1.
- dig_sel_n=4'b1100 with a valid pattern for 10 cycles -> no capture. Single select with seg_n=7'h7F -> no capture, code_err=0.
- rst_n low at TRACK cnt=2 -> all outputs 0 immediately. Separately, clear=1 on the capture edge -> values, valid and code_err are 0 and frame_done=0.
